// File: rtl/t_ff_counter_if.sv
// Bus bundle for t_ff_counter: control/data inputs and q/tc/wrap status.
// The counter module takes the slave modport; the driving side takes master.
interface t_ff_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, load, load_val, t,
        input  q, tc, wrap
    );

    modport slave (
        input  en, mode, load, load_val, t,
        output q, tc, wrap
    );
endinterface

// File: rtl/t_ff_counter.sv
// WIDTH-bit T-flip-flop register: toggle bank, up/down counter or hold, with load, tc and wrap.
// Define T_FF_CNT_SAT_EN to make UP/DOWN saturate at the terminal value (wrap tied low).
module t_ff_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic         clk,
    input  logic         rst,
    t_ff_counter_if.slave bus
);
    localparam logic [1:0] MODE_BANK = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] tog;
    logic             run_ones;
    logic             run_zeros;
    logic             terminal;

    // Terminal value of the active count direction; also the wrap condition.
    assign terminal = ((bus.mode == MODE_UP)   && (&q_r)) ||
                      ((bus.mode == MODE_DOWN) && (~|q_r));

    always_comb begin
        tog       = '0;
        run_ones  = 1'b1;
        run_zeros = 1'b1;
        case (bus.mode)
            MODE_BANK: tog = bus.t;
            MODE_UP: begin
                for (int i = 0; i < WIDTH; i++) begin
                    tog[i]   = run_ones;
                    run_ones = run_ones & q_r[i];
                end
            end
            MODE_DOWN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    tog[i]    = run_zeros;
                    run_zeros = run_zeros & ~q_r[i];
                end
            end
            default: tog = '0;
        endcase
`ifdef T_FF_CNT_SAT_EN
        if (terminal) begin
            tog = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= INIT;
        end else if (bus.load) begin
            q_r <= bus.load_val;
        end else if (bus.en) begin
            q_r <= q_r ^ tog;
        end
    end

`ifdef T_FF_CNT_SAT_EN
    assign bus.wrap = 1'b0;
`else
    logic wrap_r;

    always_ff @(posedge clk) begin
        if (rst || bus.load || !bus.en) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= terminal;
        end
    end

    assign bus.wrap = wrap_r;
`endif

    assign bus.q  = q_r;
    assign bus.tc = terminal;
endmodule

// File: tb/tb_t_ff_counter.sv
// Directed-vector bench for t_ff_counter at WIDTH=4, INIT=0.
// Vectors run back to back; each row's expectations are the state after its edge.
module tb_t_ff_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    t_ff_counter_if #(.WIDTH(W)) bus ();

    t_ff_counter #(.WIDTH(W), .INIT(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] load_val;
        logic         en;
        logic [1:0]   mode;
        logic [W-1:0] t;
        logic [W-1:0] exp_q;
        logic         exp_tc;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic [1:0] m, input logic [W-1:0] tt,
                       input logic [W-1:0] q, input logic tc, input logic wr);
        vec_t v;
        v.rst = r; v.load = ld; v.load_val = lv; v.en = e; v.mode = m; v.t = tt;
        v.exp_q = q; v.exp_tc = tc; v.exp_wrap = wr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [W-1:0] lv,
                         input logic e, input logic [1:0] m, input logic [W-1:0] tt);
        @(negedge clk);
        rst = r; bus.load = ld; bus.load_val = lv; bus.en = e; bus.mode = m; bus.t = tt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] mq;
        int           wraps;

        rst = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0;
        bus.mode = 2'b00; bus.t = '0;

        //   rst ld lv    en mode   t        q     tc wrap
        // reset dominates load; then bank toggling
        add(1, 1, 4'hA, 1, 2'b00, 4'h0,    4'h0, 0, 0);
        add(1, 1, 4'hA, 1, 2'b00, 4'h0,    4'h0, 0, 0);
        add(0, 0, 4'h0, 1, 2'b00, 4'b0101, 4'h5, 0, 0);
        add(0, 0, 4'h0, 1, 2'b00, 4'b0101, 4'h0, 0, 0);
        add(0, 0, 4'h0, 1, 2'b00, 4'b1010, 4'hA, 0, 0);
        add(0, 0, 4'h0, 0, 2'b00, 4'hF,    4'hA, 0, 0);
        // up through the wrap
        add(0, 1, 4'hD, 1, 2'b01, 4'h0,    4'hD, 0, 0);
        add(0, 0, 4'h0, 1, 2'b01, 4'hF,    4'hE, 0, 0);
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'hF, 1, 0);
`ifdef T_FF_CNT_SAT_EN
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'hF, 1, 0);
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'hF, 1, 0);
`else
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'h0, 0, 1);
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'h1, 0, 0);
`endif
        // down through the wrap
        add(0, 1, 4'h2, 1, 2'b10, 4'h0,    4'h2, 0, 0);
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'h1, 0, 0);
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'h0, 1, 0);
`ifdef T_FF_CNT_SAT_EN
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'h0, 1, 0);
`else
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'hF, 0, 1);
`endif
        // enable gating, then hold
        add(0, 1, 4'h6, 1, 2'b01, 4'h0,    4'h6, 0, 0);
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'h7, 0, 0);
        add(0, 0, 4'h0, 0, 2'b01, 4'h0,    4'h7, 0, 0);
        add(0, 0, 4'h0, 1, 2'b01, 4'h0,    4'h8, 0, 0);
        add(0, 0, 4'h0, 1, 2'b11, 4'hF,    4'h8, 0, 0);
        add(0, 0, 4'h0, 1, 2'b11, 4'hF,    4'h8, 0, 0);
        add(0, 0, 4'h0, 1, 2'b11, 4'hF,    4'h8, 0, 0);
        // load beats a wrapping increment; reset beats a wrapping increment
        add(0, 1, 4'hF, 1, 2'b01, 4'h0,    4'hF, 1, 0);
        add(0, 1, 4'h3, 1, 2'b01, 4'h0,    4'h3, 0, 0);
        add(0, 1, 4'hF, 1, 2'b01, 4'h0,    4'hF, 1, 0);
        add(1, 0, 4'h0, 1, 2'b01, 4'h0,    4'h0, 0, 0);
        // direction change mid-count
        add(0, 1, 4'h5, 1, 2'b01, 4'h0,    4'h5, 0, 0);
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'h4, 0, 0);
        add(0, 0, 4'h0, 1, 2'b10, 4'h0,    4'h3, 0, 0);
        // tc ignores en; tc is 0 in bank
        add(0, 1, 4'hF, 0, 2'b01, 4'h0,    4'hF, 1, 0);
        add(0, 0, 4'h0, 0, 2'b01, 4'h0,    4'hF, 1, 0);
        add(0, 1, 4'h0, 0, 2'b10, 4'h0,    4'h0, 1, 0);
        add(0, 0, 4'h0, 0, 2'b10, 4'h0,    4'h0, 1, 0);
        add(0, 0, 4'h0, 0, 2'b00, 4'h0,    4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].load_val, vecs[i].en,
                  vecs[i].mode, vecs[i].t);
            check("q",    i, bus.q,            vecs[i].exp_q);
            check("tc",   i, W'(bus.tc),       W'(vecs[i].exp_tc));
            check("wrap", i, W'(bus.wrap),     W'(vecs[i].exp_wrap));
        end

        // Full up cycle from 0: exactly one wrap pulse, on the step landing at 0.
        drive(0, 1, 4'h0, 0, 2'b01, 4'h0);
        mq    = 4'h0;
        wraps = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, 0, 4'h0, 1, 2'b01, 4'h0);
`ifdef T_FF_CNT_SAT_EN
            if (mq != 4'hF) mq = mq + 4'h1;
            check("sat_up_q", 100 + i, bus.q, mq);
`else
            mq = mq + 4'h1;
            check("up_q", 100 + i, bus.q, mq);
            check("up_wrap", 100 + i, W'(bus.wrap), W'(mq == 4'h0));
`endif
            if (bus.wrap) wraps++;
        end
`ifdef T_FF_CNT_SAT_EN
        check("wrap_count", 200, W'(wraps), W'(0));
`else
        check("wrap_count", 200, W'(wraps), W'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
